// File: rtl/seq_scan_ctrl.sv
// Byte-stream sequence detector: accepts bytes over valid/ready, serialises them into a
// programmable pattern matcher, counts matches and flags a threshold. Option: SEQ_LSB_FIRST_EN.
module seq_scan_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         cfg_we,
    input  logic [PAT_MAX-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_thresh,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         det_pulse,
    output logic [CNT_W-1:0]             det_count,
    output logic                         thresh_hit
);
    localparam int LEN_W = $clog2(PAT_MAX + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  byte_r;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [IDX_W-1:0]   msb_idx_s;
    logic [PAT_MAX-1:0] hist_r, cat_s, mask_s;
    logic [LEN_W-1:0]   vcnt_r;
    logic [PAT_MAX-1:0] cfg_pat_r;
    logic [LEN_W-1:0]   cfg_len_r;
    logic               cfg_ovl_r;
    logic [CNT_W-1:0]   cfg_thr_r;
    logic               in_ready_r, busy_r, det_pulse_r, thresh_hit_r;
    logic [CNT_W-1:0]   det_count_r, cnt_next_s;
    logic               accept_s, shift_s, last_s, cfg_load_s;
    logic               new_bit_s, len_ok_s, pat_ok_s, match_s;

    assign accept_s   = (state_r == IDLE) && in_valid && !clr;
    assign shift_s    = (state_r == SHIFT) && !clr;
    assign last_s     = (bit_idx_r == IDX_W'(DATA_W - 1));
    assign cfg_load_s = cfg_we && (state_r == IDLE);
    assign msb_idx_s  = IDX_W'(DATA_W - 1) - bit_idx_r;

    // Next-state logic: clr aborts any byte in flight and blocks acceptance.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr)           state_s = IDLE;
                else if (in_valid) state_s = SHIFT;
                else               state_s = IDLE;
            end
            SHIFT: begin
                if (clr || last_s) state_s = IDLE;
                else               state_s = SHIFT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            busy_r     <= (state_s == SHIFT);
        end
    end

    // Byte holding register and serialisation index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_r    <= '0;
            bit_idx_r <= '0;
        end else if (accept_s) begin
            byte_r    <= in_data;
            bit_idx_r <= '0;
        end else if (shift_s) begin
            bit_idx_r <= bit_idx_r + IDX_W'(1);
        end
    end

    // Bit selection and pattern comparison over the low cfg_len bits of {history, new bit}.
    always_comb begin
`ifdef SEQ_LSB_FIRST_EN
        new_bit_s = byte_r[bit_idx_r];
`else
        new_bit_s = byte_r[msb_idx_s];
`endif
        cat_s  = {hist_r[PAT_MAX-2:0], new_bit_s};
        mask_s = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask_s[i] = (cfg_len_r > LEN_W'(i));
        end
        len_ok_s   = (cfg_len_r != '0) &&
                     (({1'b0, vcnt_r} + (LEN_W + 1)'(1)) >= {1'b0, cfg_len_r});
        pat_ok_s   = (((cat_s ^ cfg_pat_r) & mask_s) == '0);
        match_s    = shift_s && len_ok_s && pat_ok_s;
        cnt_next_s = (det_count_r == '1) ? det_count_r : det_count_r + CNT_W'(1);
    end

    // Configuration registers; length is clamped to PAT_MAX on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_pat_r <= {{(PAT_MAX - 3){1'b0}}, 3'b101};
            cfg_len_r <= LEN_W'(3);
            cfg_ovl_r <= 1'b1;
            cfg_thr_r <= '0;
        end else if (cfg_load_s) begin
            cfg_pat_r <= cfg_pattern;
            cfg_len_r <= (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
            cfg_ovl_r <= cfg_overlap;
            cfg_thr_r <= cfg_thresh;
        end
    end

    // Match history and valid-bit count; non-overlap mode restarts the count on a match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= '0;
            vcnt_r <= '0;
        end else if (clr || cfg_load_s) begin
            hist_r <= '0;
            vcnt_r <= '0;
        end else if (shift_s) begin
            hist_r <= cat_s;
            if (match_s && !cfg_ovl_r)            vcnt_r <= '0;
            else if (vcnt_r != LEN_W'(PAT_MAX))   vcnt_r <= vcnt_r + LEN_W'(1);
        end
    end

    // Detection pulse, saturating counter and sticky threshold flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_pulse_r  <= 1'b0;
            det_count_r  <= '0;
            thresh_hit_r <= 1'b0;
        end else if (clr) begin
            det_pulse_r  <= 1'b0;
            det_count_r  <= '0;
            thresh_hit_r <= 1'b0;
        end else begin
            det_pulse_r <= match_s;
            if (match_s) begin
                det_count_r <= cnt_next_s;
                if ((cfg_thr_r != '0) && (cnt_next_s >= cfg_thr_r)) thresh_hit_r <= 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign det_pulse  = det_pulse_r;
    assign det_count  = det_count_r;
    assign thresh_hit = thresh_hit_r;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl; expected values are hand-derived bit traces.
module tb_seq_scan_ctrl;
    logic       clk = 1'b0;
    logic       reset, clr, cfg_we, cfg_overlap, in_valid;
    logic [7:0] cfg_pattern, cfg_thresh, in_data;
    logic [3:0] cfg_len;
    logic       in_ready, busy, det_pulse, thresh_hit;
    logic [7:0] det_count;
    logic [7:0] pm, tm;
    int checks = 0;
    int errors = 0;

    seq_scan_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clr(clr), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .det_pulse(det_pulse), .det_count(det_count), .thresh_hit(thresh_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic [7:0] th);
        @(negedge clk);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_thresh = th; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Sends one byte; pmask/tmask[k] hold det_pulse/thresh_hit after the edge consuming bit k.
    task automatic send_byte(input logic [7:0] b, input logic cfg_mid,
                             output logic [7:0] pmask, output logic [7:0] tmask);
        @(negedge clk);
        check("ready_before_send", in_ready, 1'b1);
        in_valid = 1'b1; in_data = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pmask = 8'h00; tmask = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            pmask[k] = det_pulse;
            tmask[k] = thresh_hit;
            if (cfg_mid && k == 0) cfg_we = 1'b1;
            if (k == 1) cfg_we = 1'b0;
        end
        check("ready_after_byte", in_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_overlap = 1'b0; in_valid = 1'b0;
        cfg_pattern = 8'h00; cfg_thresh = 8'h00; in_data = 8'h00; cfg_len = 4'd0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_det_pulse", det_pulse, 1'b0);
        check("rst_det_count", det_count, 8'd0);
        check("rst_thresh_hit", thresh_hit, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Default config 101/len3/overlap: 0xA5 matches at bits 2 and 7.
        send_byte(8'hA5, 1'b0, pm, tm);
        check("a5_pulses", pm, 8'h84);
        check("a5_count", det_count, 8'd2);

        do_clr();
        send_byte(8'hAA, 1'b0, pm, tm);
        check("aa_ovl_pulses", pm, 8'h54);
        check("aa_ovl_count", det_count, 8'd3);
        do_clr();
        cfg_write(8'h05, 4'd3, 1'b0, 8'd0);
        send_byte(8'hAA, 1'b0, pm, tm);
        check("aa_noovl_pulses", pm, 8'h44);
        check("aa_noovl_count", det_count, 8'd2);

        // Match straddling a byte boundary.
        cfg_write(8'h05, 4'd3, 1'b1, 8'd0);
        do_clr();
        send_byte(8'h01, 1'b0, pm, tm);
        check("x01_pulses", pm, 8'h00);
        send_byte(8'h40, 1'b0, pm, tm);
        check("x40_pulses", pm, 8'h02);
        check("cross_count", det_count, 8'd1);

        // Threshold 3, then saturation.
        cfg_write(8'h05, 4'd3, 1'b1, 8'd3);
        do_clr();
        send_byte(8'hAA, 1'b0, pm, tm);
        check("thr_pulses1", pm, 8'h54);
        check("thr_flag1", tm, 8'hC0);
        check("thr_count1", det_count, 8'd3);
        send_byte(8'hAA, 1'b0, pm, tm);
        check("thr_pulses2", pm, 8'h55);
        check("thr_flag2", tm, 8'hFF);
        check("thr_count2", det_count, 8'd7);
        cfg_write(8'h01, 4'd1, 1'b1, 8'd3);
        for (int n = 0; n < 30; n++) send_byte(8'hFF, 1'b0, pm, tm);
        check("sat_pre_count", det_count, 8'd247);
        for (int n = 0; n < 8; n++) send_byte(8'hFF, 1'b0, pm, tm);
        check("sat_count", det_count, 8'd255);
        check("sat_thresh", thresh_hit, 1'b1);

        // Length 15 clamps to 8.
        do_clr();
        cfg_write(8'hFF, 4'd15, 1'b1, 8'd0);
        send_byte(8'hFF, 1'b0, pm, tm);
        check("clamp_pulses", pm, 8'h80);
        check("clamp_count", det_count, 8'd1);

        // Config write while busy is ignored.
        do_clr();
        cfg_write(8'h05, 4'd3, 1'b1, 8'd0);
        cfg_pattern = 8'h0F; cfg_len = 4'd4;
        send_byte(8'hA5, 1'b1, pm, tm);
        check("busy_cfg_pulses", pm, 8'h84);
        send_byte(8'hA5, 1'b0, pm, tm);
        check("busy_cfg_pulses2", pm, 8'h84);
        check("busy_cfg_count", det_count, 8'd4);

        // clr mid-byte.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clr_pre_busy", busy, 1'b1);
        check("clr_pre_count", det_count, 8'd5);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_in_ready", in_ready, 1'b1);
        check("clr_busy", busy, 1'b0);
        check("clr_count", det_count, 8'd0);
        @(negedge clk);
        clr = 1'b0;

        // Async reset mid-byte.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ar_pre_count", det_count, 8'd1);
        check("ar_pre_pulse", det_pulse, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_busy", busy, 1'b0);
        check("ar_pulse", det_pulse, 1'b0);
        check("ar_count", det_count, 8'd0);
        check("ar_thresh", thresh_hit, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Bit order: 0x05 against default 101 pattern.
        send_byte(8'h05, 1'b0, pm, tm);
`ifdef SEQ_LSB_FIRST_EN
        check("order_pulses", pm, 8'h04);
`else
        check("order_pulses", pm, 8'h80);
`endif
        check("order_count", det_count, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
